// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch and PC-sequencing stage ahead of the opcode decoder.
//
// Two-state FSM. FETCH requests the word at pc from instruction memory until imem_ready,
// then latches it. EXEC holds the word for the decoder/datapath until exec_done, then
// resolves next-PC from Jump/Branch, the ALU zero flag and rs_val.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/addr/ready/rdata instruction memory handshake (addr = pc)
//   instr, op, instr_valid    latched instruction, its op field, and the held flag
//   exec_done                 datapath finished; Jump/Branch/zero/rs_val valid this cycle
//   Jump, Branch, zero        decoder jump flag, branch code, ALU zero flag
//   rs_val                    rs value for sign-based branch conditions
//   pc, pc_plus4              current instruction address and link value
//
// Optional feature: define FETCH_DELAY_SLOT_EN for MIPS branch delay-slot semantics
// (redirect deferred by one instruction, link value pc+8).

module fetch_pc_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              Jump,
    input  logic [2:0]        Branch,
    input  logic              zero,
    input  logic [31:0]       rs_val,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    typedef enum logic {StFetch, StExec} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] redirect_target;
    logic              branch_taken;
    logic              redirect;
    logic              rs_neg;
    logic              rs_zero;

    // Address of the sequentially next instruction; also the base for both targets.
    assign seq_pc = pc_q + ADDR_W'(4);

    // Sign-extended word offset, wrapping modulo 2^ADDR_W.
    assign branch_target = seq_pc + ADDR_W'($signed({instr_q[15:0], 2'b00}));

    // Keep the upper region bits of seq_pc, replace the low 28 bits with the index.
    assign jump_target = (seq_pc & ~ADDR_W'(32'h0FFF_FFFF))
                       | ADDR_W'({instr_q[25:0], 2'b00});

    assign rs_neg  = rs_val[31];
    assign rs_zero = (rs_val == 32'd0);

    always_comb begin
        branch_taken = 1'b0;
        unique case (Branch)
            3'b001:  branch_taken = zero;
            3'b010:  branch_taken = !zero;
            3'b011:  branch_taken = !rs_neg;
            3'b100:  branch_taken = rs_neg | rs_zero;
            3'b101:  branch_taken = !rs_neg & !rs_zero;
            3'b111:  branch_taken = rs_neg;
            default: branch_taken = 1'b0;
        endcase
    end

    assign redirect        = Jump | branch_taken;
    assign redirect_target = Jump ? jump_target : branch_target;

`ifdef FETCH_DELAY_SLOT_EN
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_DELAY_SLOT_EN
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
`endif
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (exec_done) begin
                    valid_d = 1'b0;
                    state_d = StFetch;
`ifdef FETCH_DELAY_SLOT_EN
                    if (pend_q) begin
                        // Delay slot retiring: a jump/branch in the slot is ignored.
                        pc_d   = pend_target_q;
                        pend_d = 1'b0;
                    end else begin
                        pc_d = seq_pc;
                        if (redirect) begin
                            pend_d        = 1'b1;
                            pend_target_d = redirect_target;
                        end
                    end
`else
                    pc_d = redirect ? redirect_target : seq_pc;
`endif
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_q        <= 1'b0;
            pend_target_q <= RESET_PC;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef FETCH_DELAY_SLOT_EN
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
`endif
        end
    end

    assign imem_req    = (state_q == StFetch) && !rst;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign instr_valid = valid_q;
    assign pc          = pc_q;

`ifdef FETCH_DELAY_SLOT_EN
    // Link past the delay slot.
    assign pc_plus4 = pc_q + ADDR_W'(8);
`else
    assign pc_plus4 = seq_pc;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit (default build). Expected fetch addresses are pushed
// to a queue when each instruction is executed and popped when the next fetch is seen.

module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic        exec_done;
    logic        Jump;
    logic [2:0]  Branch;
    logic        zero;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;
    logic [31:0] addr_q[$];

    fetch_pc_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .Jump        (Jump),
        .Branch      (Branch),
        .zero        (zero),
        .rs_val      (rs_val),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch after `waits` wait states; exec_done is pulsed meanwhile and must
    // be ignored outside EXEC.
    task automatic fetch(input logic [31:0] data, input int waits);
        logic [31:0] exp_addr;
        if (addr_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            exp_addr = 32'hFFFF_FFFF;
        end else begin
            exp_addr = addr_q.pop_front();
        end
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            exec_done  = 1'b1;
            #1;
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp_addr);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        exec_done  = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = data;
        #1;
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("latch_valid", {31'd0, instr_valid}, 32'd1);
        chk("latch_instr", instr, data);
        chk("latch_op", {26'd0, op}, {26'd0, data[31:26]});
    endtask

    // Hold the instruction in EXEC for `hold` cycles (imem_ready pulsed, must be ignored),
    // then complete it with the given resolve inputs.
    task automatic exec(input logic j, input logic [2:0] br, input logic z,
                        input logic [31:0] rs, input int hold, input logic [31:0] data,
                        input logic [31:0] cur_pc, input logic [31:0] next_pc);
        addr_q.push_back(next_pc);
        for (int i = 0; i < hold; i++) begin
            imem_ready = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
            #1;
            chk("exec_req", {31'd0, imem_req}, 32'd0);
            chk("exec_instr_hold", instr, data);
            chk("exec_pc", pc, cur_pc);
            chk("exec_pc_plus4", pc_plus4, cur_pc + 32'd4);
            step();
        end
        imem_ready = 1'b0;
        Jump       = j;
        Branch     = br;
        zero       = z;
        rs_val     = rs;
        exec_done  = 1'b1;
        step();
        exec_done = 1'b0;
        Jump      = 1'b0;
        Branch    = 3'b000;
        zero      = 1'b0;
        rs_val    = 32'd0;
        #1;
        chk("done_valid", {31'd0, instr_valid}, 32'd0);
        chk("done_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        exec_done  = 1'b0;
        Jump       = 1'b0;
        Branch     = 3'b000;
        zero       = 1'b0;
        rs_val     = 32'd0;

        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);

        // Sequential flow
        addr_q.push_back(32'h0);
        fetch(32'h0000_0020, 0);
        exec(1'b0, 3'b000, 1'b0, 32'd0, 1, 32'h0000_0020, 32'h0, 32'h4);
        fetch(32'h0000_0020, 0);
        exec(1'b0, 3'b000, 1'b0, 32'd0, 0, 32'h0000_0020, 32'h4, 32'h8);

        // Wait states at 0x8, J to 0x10
        fetch(32'h0800_0004, 3);
        exec(1'b1, 3'b000, 1'b0, 32'd0, 1, 32'h0800_0004, 32'h8, 32'h10);

        // BEQ not taken, loop back, BEQ taken
        fetch(32'h1000_0003, 0);
        exec(1'b0, 3'b001, 1'b0, 32'd0, 0, 32'h1000_0003, 32'h10, 32'h14);
        fetch(32'h0800_0004, 0);
        exec(1'b1, 3'b000, 1'b0, 32'd0, 0, 32'h0800_0004, 32'h14, 32'h10);
        fetch(32'h1000_0003, 0);
        exec(1'b0, 3'b001, 1'b1, 32'd0, 1, 32'h1000_0003, 32'h10, 32'h20);

        // BLTZ taken back onto itself, then BGEZ not taken with negative rs
        fetch(32'h0400_FFFF, 1);
        exec(1'b0, 3'b111, 1'b0, 32'h8000_0000, 0, 32'h0400_FFFF, 32'h20, 32'h20);
        fetch(32'h0400_FFFF, 0);
        exec(1'b0, 3'b011, 1'b1, 32'h8000_0000, 0, 32'h0400_FFFF, 32'h20, 32'h24);

        // BLEZ on zero taken, BGTZ on positive taken, reserved code never taken
        fetch(32'h1800_FFFF, 0);
        exec(1'b0, 3'b100, 1'b0, 32'd0, 0, 32'h1800_FFFF, 32'h24, 32'h24);
        fetch(32'h1C00_FFFF, 0);
        exec(1'b0, 3'b101, 1'b0, 32'd5, 0, 32'h1C00_FFFF, 32'h24, 32'h24);
        fetch(32'h1C00_FFFF, 0);
        exec(1'b0, 3'b110, 1'b1, 32'h8000_0000, 0, 32'h1C00_FFFF, 32'h24, 32'h28);

        // J to 0x100, then jump wins over a taken BEQ
        fetch(32'h0800_0040, 0);
        exec(1'b1, 3'b000, 1'b0, 32'd0, 0, 32'h0800_0040, 32'h28, 32'h100);
        fetch(32'h0800_0100, 0);
        exec(1'b1, 3'b001, 1'b1, 32'd0, 2, 32'h0800_0100, 32'h100, 32'h400);
        fetch(32'h0800_0010, 0);
        exec(1'b1, 3'b000, 1'b0, 32'd0, 0, 32'h0800_0010, 32'h400, 32'h40);

        // Reset in the middle of EXEC at 0x40
        fetch(32'h0000_0020, 0);
        rst = 1'b1;
        step();
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        rst = 1'b0;
        void'(addr_q.pop_front());
        addr_q.push_back(32'h0);
        #1;
        fetch(32'h0000_0020, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
